// File: rtl/rom_arb.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// rom_arb
//   Two-requester round-robin arbiter in front of a single synchronous ROM
//   controller. One read is in flight at a time. The FSM walks
//   IDLE -> READ -> CAPT -> RESP: READ presents the address to the ROM, CAPT
//   waits for the registered ROM output, and RESP holds the captured word
//   until the owning requester accepts it.
//
// Parameters
//   ADDR_W  ROM address width
//   DATA_W  ROM data width
//
// Ports
//   i_clk        clock, all state on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_req_valid  per-requester read request (bit k = requester k)
//   i_req_addr0  requester 0 read address
//   i_req_addr1  requester 1 read address
//   o_req_ready  per-requester request accept (at most one bit high)
//   o_rsp_valid  per-requester response valid (at most one bit high)
//   i_rsp_ready  per-requester response accept
//   o_rsp_data   response word for the requester whose o_rsp_valid is high
//   o_rom_en     ROM enable, high only while the address is presented
//   o_rom_addr   ROM address
//   i_rom_data   ROM read data, valid the cycle after o_rom_en is sampled
// -----------------------------------------------------------------------------
module rom_arb #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [1:0]        i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr0,
  input  logic [ADDR_W-1:0] i_req_addr1,
  output logic [1:0]        o_req_ready,
  output logic [1:0]        o_rsp_valid,
  input  logic [1:0]        i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rom_en,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Round-robin pointer: when both requesters are valid, requester 1 wins
  // if favour1 is set. Reset favours requester 0.
  logic favour1;

  logic              sel_vld;
  logic              sel_id;
  logic [ADDR_W-1:0] sel_addr;
  logic              accept;

  // Transaction owner and address, captured on accept
  logic              id_p0;
  logic [ADDR_W-1:0] addr_p0;

  // Response word, captured from the ROM at the CAPT -> RESP edge
  logic [DATA_W-1:0] rsp_data_p2;

  // Requester selection, evaluated every cycle but only used in IDLE
  always_comb begin
    sel_vld = |i_req_valid;
    sel_id  = 1'b0;
    case (i_req_valid)
      2'b01:   sel_id = 1'b0;
      2'b10:   sel_id = 1'b1;
      2'b11:   sel_id = favour1;
      default: sel_id = 1'b0;
    endcase
    sel_addr = sel_id ? i_req_addr1 : i_req_addr0;
  end

  // Next state and outputs
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    o_req_ready = 2'b00;
    o_rsp_valid = 2'b00;
    o_rom_en    = 1'b0;
    o_rom_addr  = '0;
    case (state)
      IDLE: begin
        // Gate with reset so no accept is advertised while reset is held
        if (sel_vld && i_rst_n) begin
          o_req_ready[sel_id] = 1'b1;
          accept              = 1'b1;
          state_nxt           = READ;
        end
      end
      READ: begin
        o_rom_en   = 1'b1;
        o_rom_addr = addr_p0;
        state_nxt  = CAPT;
      end
      CAPT: begin
        state_nxt = RESP;
      end
      RESP: begin
        o_rsp_valid[id_p0] = 1'b1;
        // Only the owner's ready bit matters
        if (i_rsp_ready[id_p0]) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_rsp_data = rsp_data_p2;

  // Control state and response register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      favour1     <= 1'b0;
      id_p0       <= 1'b0;
      rsp_data_p2 <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        id_p0   <= sel_id;
        // Pointer moves only on an accept, towards the requester not served
        favour1 <= ~sel_id;
      end
      if (state == CAPT) begin
        rsp_data_p2 <= i_rom_data;
      end else if (state == RESP && i_rsp_ready[id_p0]) begin
        // Response data reads as zero whenever no response is offered
        rsp_data_p2 <= '0;
      end
    end
  end

  // Address capture; only observed through o_rom_addr in READ, so no reset
  always_ff @(posedge i_clk) begin
    if (accept) begin
      addr_p0 <= sel_addr;
    end
  end

endmodule

// File: tb/tb_rom_arb.sv
`timescale 1ns/1ps
module tb_rom_arb;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [7:0] addr0;
  logic [7:0] addr1;
  logic [1:0] req_ready;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  logic [7:0] rsp_data;
  logic       rom_en;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;

  logic [7:0] rom [256];

  int checks   = 0;
  int failures = 0;

  rom_arb #(.ADDR_W(8), .DATA_W(8)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_addr0 (addr0),
    .i_req_addr1 (addr1),
    .o_req_ready (req_ready),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_data  (rsp_data),
    .o_rom_en    (rom_en),
    .o_rom_addr  (rom_addr),
    .i_rom_data  (rom_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: data appears the cycle after enable is sampled, zero otherwise
  always @(posedge clk) rom_data <= rom_en ? rom[rom_addr] : 8'h00;

  // ---------------------------------------------------------------------------
  // Transaction-level reference: one read outstanding at a time, grant by
  // round-robin on ties, ROM strobe one cycle after accept, response from the
  // third cycle after accept until the owner takes it.
  // ---------------------------------------------------------------------------
  int         cyc = 0;
  bit         inflight = 1'b0;
  int         acc_cyc = 0;
  bit         m_id = 1'b0;
  bit         m_last = 1'b1;
  logic [7:0] m_addr = 8'h00;
  logic [1:0] e_ready, e_rv;
  logic       e_en;
  logic [7:0] e_addr, e_data;
  bit         g;
  int         k;

  always @(negedge clk) begin
    cyc     = cyc + 1;
    e_ready = 2'b00;
    e_rv    = 2'b00;
    e_en    = 1'b0;
    e_addr  = 8'h00;
    e_data  = 8'h00;
    g       = 1'b0;
    k       = 0;
    if (!rst_n) begin
      inflight = 1'b0;
      m_last   = 1'b1;
    end else if (!inflight) begin
      if (req_valid == 2'b11) g = !m_last;
      else                    g = req_valid[1];
      if (req_valid != 2'b00) e_ready[g] = 1'b1;
    end else begin
      k = cyc - acc_cyc;
      if (k == 1) begin
        e_en   = 1'b1;
        e_addr = m_addr;
      end
      if (k >= 3) begin
        e_rv[m_id] = 1'b1;
        e_data     = rom[m_addr];
      end
    end
    checks++;
    if (req_ready !== e_ready) begin
      failures++;
      $display("FAIL mon_req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_ready);
    end
    checks++;
    if (rsp_valid !== e_rv) begin
      failures++;
      $display("FAIL mon_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, e_rv);
    end
    checks++;
    if (rom_en !== e_en) begin
      failures++;
      $display("FAIL mon_rom_en cyc=%0d got=%b exp=%b", cyc, rom_en, e_en);
    end
    checks++;
    if (rom_addr !== e_addr) begin
      failures++;
      $display("FAIL mon_rom_addr cyc=%0d got=%h exp=%h", cyc, rom_addr, e_addr);
    end
    checks++;
    if (rsp_data !== e_data) begin
      failures++;
      $display("FAIL mon_rsp_data cyc=%0d got=%h exp=%h", cyc, rsp_data, e_data);
    end
    checks++;
    if (!$onehot0(req_ready) || !$onehot0(rsp_valid)) begin
      failures++;
      $display("FAIL mon_onehot cyc=%0d got ready=%b valid=%b exp at most one bit", cyc, req_ready, rsp_valid);
    end
    if (rst_n) begin
      if (!inflight && req_valid != 2'b00) begin
        inflight = 1'b1;
        acc_cyc  = cyc;
        m_id     = g;
        m_addr   = g ? addr1 : addr0;
        m_last   = g;
      end else if (inflight && k >= 3 && rsp_ready[m_id]) begin
        inflight = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus(input int n);
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    repeat (n) step();
  endtask

  function automatic logic [7:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 8'h00;
      1:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    req_valid = 2'b11;
    addr0     = 8'h33;
    addr1     = 8'h44;
    rsp_ready = 2'b11;
    step();
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rom_en} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000", {req_ready, rsp_valid, rom_en});
    end
    checks++;
    if ({rom_addr, rsp_data} !== 16'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0000", {rom_addr, rsp_data});
    end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL reset_first_grant got=%b exp=01", req_ready);
    end
    step();
    req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (rom_en !== 1'b1 || rom_addr !== 8'h33) begin
      failures++;
      $display("FAIL reset_first_read got=%b/%h exp=1/33", rom_en, rom_addr);
    end
    step();
    idle_bus(5);
  endtask

  task automatic test_single();
    idle_bus(2);
    req_valid = 2'b01;
    addr0     = 8'h04;
    rsp_ready = 2'b01;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL single_ready got=%b exp=01", req_ready);
    end
    step();
    req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (rom_en !== 1'b1 || rom_addr !== 8'h04) begin
      failures++;
      $display("FAIL single_rom got=%b/%h exp=1/04", rom_en, rom_addr);
    end
    step();
    @(negedge clk);
    checks++;
    if (rom_en !== 1'b0 || rsp_valid !== 2'b00) begin
      failures++;
      $display("FAIL single_capt got=%b/%b exp=0/00", rom_en, rsp_valid);
    end
    step();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b01 || rsp_data !== rom[8'h04]) begin
      failures++;
      $display("FAIL single_rsp got=%b/%h exp=01/%h", rsp_valid, rsp_data, rom[8'h04]);
    end
    step();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b00 || rsp_data !== 8'h00) begin
      failures++;
      $display("FAIL single_done got=%b/%h exp=00/00", rsp_valid, rsp_data);
    end
    idle_bus(2);
  endtask

  task automatic test_both();
    bit         order[$];
    logic [7:0] d0, d1;
    bit         got0, got1;
    logic [1:0] acc;
    idle_bus(2);
    rst_n = 1'b0;
    step();
    step();
    rst_n     = 1'b1;
    req_valid = 2'b11;
    addr0     = 8'h01;
    addr1     = 8'h80;
    rsp_ready = 2'b11;
    got0 = 0; got1 = 0; d0 = 0; d1 = 0;
    for (int i = 0; i < 30 && !(got0 && got1); i++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      if (acc[0]) order.push_back(1'b0);
      if (acc[1]) order.push_back(1'b1);
      if (rsp_valid[0]) begin got0 = 1; d0 = rsp_data; end
      if (rsp_valid[1]) begin got1 = 1; d1 = rsp_data; end
      step();
      req_valid = req_valid & ~acc;
    end
    checks++;
    if (!(got0 && got1) || order.size() != 2) begin
      failures++;
      $display("FAIL both_complete got=%0d grants exp=2", order.size());
    end else begin
      checks++;
      if (order[0] !== 1'b0 || order[1] !== 1'b1) begin
        failures++;
        $display("FAIL both_order got=%b,%b exp=0,1", order[0], order[1]);
      end
      checks++;
      if (d0 !== rom[8'h01]) begin
        failures++;
        $display("FAIL both_data0 got=%h exp=%h", d0, rom[8'h01]);
      end
      checks++;
      if (d1 !== rom[8'h80]) begin
        failures++;
        $display("FAIL both_data1 got=%h exp=%h", d1, rom[8'h80]);
      end
    end
    idle_bus(3);
  endtask

  task automatic test_back_to_back();
    int         rcyc [8];
    logic [7:0] rdat [8];
    int         n, idx;
    bit         acc;
    logic [7:0] a;
    idle_bus(2);
    rsp_ready = 2'b01;
    req_valid = 2'b01;
    addr0     = 8'h01;
    n = 0; idx = 0;
    for (int i = 0; i < 60 && n < 8; i++) begin
      @(negedge clk);
      acc = req_valid[0] && req_ready[0];
      if (rsp_valid[0]) begin
        rcyc[n] = i;
        rdat[n] = rsp_data;
        n++;
      end
      step();
      if (acc) begin
        idx++;
        if (idx == 8) req_valid = 2'b00;
        else          addr0 = 8'(1 << idx);
      end
    end
    checks++;
    if (n != 8) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=8", n);
    end else begin
      for (int i = 0; i < 8; i++) begin
        a = 8'(1 << i);
        checks++;
        if (rdat[i] !== rom[a]) begin
          failures++;
          $display("FAIL b2b_data[%0d] got=%h exp=%h", i, rdat[i], rom[a]);
        end
        if (i > 0) begin
          checks++;
          if (rcyc[i] - rcyc[i-1] != 4) begin
            failures++;
            $display("FAIL b2b_gap[%0d] got=%0d exp=4", i, rcyc[i] - rcyc[i-1]);
          end
        end
      end
    end
    idle_bus(3);
  endtask

  task automatic test_backpressure();
    logic [7:0] a, b, held;
    bit         seen;
    idle_bus(2);
    a = rand_addr();
    b = rand_addr();
    rsp_ready = 2'b10;
    req_valid = 2'b01;
    addr0     = a;
    @(negedge clk);
    step();
    req_valid = 2'b10;
    addr1     = b;
    seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid[0]) seen = 1;
      else step();
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL bp_timeout got=no response exp=response");
    end else begin
      held = rsp_data;
      checks++;
      if (held !== rom[a]) begin
        failures++;
        $display("FAIL bp_data got=%h exp=%h", held, rom[a]);
      end
      for (int i = 0; i < 5; i++) begin
        step();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 2'b01 || rsp_data !== held || req_ready !== 2'b00 || rom_en !== 1'b0) begin
          failures++;
          $display("FAIL bp_hold[%0d] got=%b/%h/%b/%b exp=01/%h/00/0", i, rsp_valid, rsp_data, req_ready, rom_en, held);
        end
      end
      step();
      rsp_ready = 2'b01;
      step();
      @(negedge clk);
      checks++;
      if (rsp_valid !== 2'b00 || req_ready !== 2'b10) begin
        failures++;
        $display("FAIL bp_release got=%b/%b exp=00/10", rsp_valid, req_ready);
      end
    end
    step();
    idle_bus(6);
  endtask

  task automatic test_reset_midflight();
    logic [7:0] a;
    for (int p = 0; p < 2; p++) begin
      idle_bus(3);
      a = (p == 0) ? 8'hFF : rand_addr();
      if (p == 0) begin req_valid = 2'b10; addr1 = a; end
      else        begin req_valid = 2'b01; addr0 = a; end
      @(negedge clk);
      step();
      req_valid = 2'b00;
      @(negedge clk);
      checks++;
      if (rom_en !== 1'b1 || rom_addr !== a) begin
        failures++;
        $display("FAIL rst_mid_read[%0d] got=%b/%h exp=1/%h", p, rom_en, rom_addr, a);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({req_ready, rsp_valid, rom_en, rom_addr, rsp_data} !== 21'h0) begin
        failures++;
        $display("FAIL rst_mid_zero[%0d] got=%b/%b/%b/%h/%h exp=all zero", p, req_ready, rsp_valid, rom_en, rom_addr, rsp_data);
      end
      step();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        checks++;
        if (rsp_valid !== 2'b00) begin
          failures++;
          $display("FAIL rst_mid_norsp[%0d] got=%b exp=00", p, rsp_valid);
        end
        step();
      end
      req_valid = 2'b11;
      addr0     = rand_addr();
      addr1     = rand_addr();
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b01) begin
        failures++;
        $display("FAIL rst_mid_grant[%0d] got=%b exp=01", p, req_ready);
      end
      step();
      req_valid = 2'b00;
    end
    idle_bus(5);
  endtask

  task automatic test_random();
    logic [7:0] pend0[$], pend1[$];
    logic [7:0] a;
    logic [1:0] acc;
    int         nresp;
    idle_bus(3);
    nresp = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      if (acc[0]) pend0.push_back(addr0);
      if (acc[1]) pend1.push_back(addr1);
      if (rsp_valid[0] && rsp_ready[0]) begin
        nresp++;
        checks++;
        if (pend0.size() == 0) begin
          failures++;
          $display("FAIL rand_rsp0 got=unexpected response exp=none");
        end else begin
          a = pend0.pop_front();
          if (rsp_data !== rom[a]) begin
            failures++;
            $display("FAIL rand_rsp0 addr=%h got=%h exp=%h", a, rsp_data, rom[a]);
          end
        end
      end
      if (rsp_valid[1] && rsp_ready[1]) begin
        nresp++;
        checks++;
        if (pend1.size() == 0) begin
          failures++;
          $display("FAIL rand_rsp1 got=unexpected response exp=none");
        end else begin
          a = pend1.pop_front();
          if (rsp_data !== rom[a]) begin
            failures++;
            $display("FAIL rand_rsp1 addr=%h got=%h exp=%h", a, rsp_data, rom[a]);
          end
        end
      end
      step();
      // Requesters hold valid and address until accepted
      if (!req_valid[0] || acc[0]) begin
        req_valid[0] = ($urandom_range(0, 2) != 0);
        addr0        = rand_addr();
      end
      if (!req_valid[1] || acc[1]) begin
        req_valid[1] = ($urandom_range(0, 2) != 0);
        addr1        = rand_addr();
      end
      rsp_ready = 2'($urandom_range(0, 3));
    end
    checks++;
    if (nresp < 20) begin
      failures++;
      $display("FAIL rand_progress got=%0d exp>=20", nresp);
    end
    idle_bus(8);
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    rst_n     = 1'b1;
    req_valid = 2'b00;
    addr0     = 8'h00;
    addr1     = 8'h00;
    rsp_ready = 2'b00;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    #2;
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_both();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog got=timeout exp=completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
